// File: rtl/regfile_wb_if.sv
// ALU-side bus of the register-file / write-back stage.
// master: regfile_wb (drives sr1, sr2, pc; sinks the ALU result q).
// slave : ALU (sinks sr1, sr2, pc; drives its registered result q).
interface regfile_wb_if;
  logic [15:0] sr1;
  logic [15:0] sr2;
  logic [15:0] pc;
  logic [15:0] q;

  modport master (output sr1, output sr2, output pc, input q);
  modport slave  (input sr1, input sr2, input pc, output q);
endinterface

// File: rtl/regfile_wb.sv
// Register file, program counter and write-back stage of the multi-phase CPU.
// Feeds sr1/sr2/pc to the ALU and writes the ALU's registered result back
// to R[rd] or to the pc at the end of PH3.
// Ports:
//   CLK, RSTN   clock, asynchronous active-low reset
//   ph          one-hot phase code (PH0..PH3), one cycle per phase
//   ir          current instruction; rd = ir[10:8], rs2 = ir[7:5], opcode = ir[15:11]
//   alu         regfile_wb_if.master: sr1/sr2 (combinational reads), pc, q (ALU result)
//   wb_valid    one-cycle pulse after a register write
//   wb_addr     index of the last register write
// Configuration macro: REGFILE_R0_ZERO_EN -- R0 reads as zero and ignores writes.
module regfile_wb #(
  parameter int unsigned NREG = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [3:0]    ph,
  input  logic [15:0]   ir,
  regfile_wb_if.master  alu,
  output logic          wb_valid,
  output logic [2:0]    wb_addr
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  // Phase and opcode encodings shared with the rest of the CPU.
  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_LI  = 5'b00010;
  localparam logic [4:0] OP_B   = 5'b00011;
  localparam logic [4:0] OP_BNZ = 5'b00100;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] pc_q, pc_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;

  logic [AW-1:0] rd;
  logic [AW-1:0] rs2;

  assign rd  = ir[10:8];
  assign rs2 = ir[7:5];

  // Next-state: phase/opcode decode, first matching pattern wins.
  always_comb begin
    regs_d     = regs_q;
    pc_d       = pc_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;

    casez ({ph, ir})
      {PH0, 16'b????????????????}: begin
      end
      {PH1, 16'b????????????????}: begin
        pc_d = pc_q + DW'(1);
      end
      {PH2, 16'b????????????????}: begin
      end
      {PH3, OP_ADD, 11'b???????????},
      {PH3, OP_LI,  11'b???????????}: begin
`ifdef REGFILE_R0_ZERO_EN
        if (rd != AW'(0)) begin
          regs_d[rd] = alu.q;
        end
`else
        regs_d[rd] = alu.q;
`endif
        wb_valid_d = 1'b1;
        wb_addr_d  = rd;
      end
      // A not-taken BNZ arrives with q == pc, so the pc simply holds.
      {PH3, OP_B,   11'b???????????},
      {PH3, OP_BNZ, 11'b???????????}: begin
        pc_d = alu.q;
      end
      default: begin
      end
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pc_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      pc_q       <= pc_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
    end
  end

  // Combinational operand reads, no write bypass.
  always_comb begin
    alu.sr1 = regs_q[rd];
    alu.sr2 = regs_q[rs2];
`ifdef REGFILE_R0_ZERO_EN
    if (rd == AW'(0)) begin
      alu.sr1 = '0;
    end
    if (rs2 == AW'(0)) begin
      alu.sr2 = '0;
    end
`endif
  end

  assign alu.pc   = pc_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios plus randomized phase/instruction
// traffic, checked every cycle against a behavioural model of the stage.
module tb_regfile_wb;

  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_LI  = 5'b00010;
  localparam logic [4:0] OP_B   = 5'b00011;
  localparam logic [4:0] OP_BNZ = 5'b00100;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        CLK;
  logic        RSTN;
  logic [3:0]  ph;
  logic [15:0] ir;
  logic [15:0] q;
  logic        wb_valid;
  logic [2:0]  wb_addr;

  regfile_wb_if alu_if ();
  assign alu_if.q = q;

  regfile_wb dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .ph       (ph),
    .ir       (ir),
    .alu      (alu_if),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  logic [15:0] m_regs [8];
  logic [15:0] m_pc;
  logic        m_wbv;
  logic [2:0]  m_wba;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (R0Z && a == 3'd0) return 16'h0000;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_pc  = 16'h0000;
    m_wbv = 1'b0;
    m_wba = 3'd0;
  endtask

  // What one clock edge does to the architectural state, given the held inputs.
  task automatic model_edge();
    logic [4:0] op;
    logic [2:0] rdx;
    if (!RSTN) begin
      model_reset();
    end else begin
      op    = ir[15:11];
      rdx   = ir[10:8];
      m_wbv = 1'b0;
      if (ph == PH1) begin
        m_pc = m_pc + 16'd1;
      end else if (ph == PH3) begin
        if (op == OP_ADD || op == OP_LI) begin
          if (!(R0Z && rdx == 3'd0)) m_regs[rdx] = q;
          m_wbv = 1'b1;
          m_wba = rdx;
        end else if (op == OP_B || op == OP_BNZ) begin
          m_pc = q;
        end
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("sr1", alu_if.sr1, exp_rd(ir[10:8]));
      check("sr2", alu_if.sr2, exp_rd(ir[7:5]));
      check("pc", alu_if.pc, m_pc);
      check("wb_valid", 16'(wb_valid), 16'(m_wbv));
      check("wb_addr", 16'(wb_addr), 16'(m_wba));
    end
  end

  // Drive inputs, take one edge, advance the model; returns 2 time units after the edge.
  task automatic drive(input logic [3:0] p, input logic [15:0] i, input logic [15:0] qv);
    ph = p;
    ir = i;
    q  = qv;
    @(posedge CLK);
    model_edge();
    #2;
  endtask

  task automatic instr(input logic [15:0] i, input logic [15:0] qv);
    drive(PH0, i, qv);
    drive(PH1, i, qv);
    drive(PH2, i, qv);
    drive(PH3, i, qv);
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rdx,
                                     input logic [2:0] rs, input logic [4:0] lo);
    return {op, rdx, rs, lo};
  endfunction

  initial begin
    logic [15:0] add_i;
    logic [15:0] qv;
    logic [3:0]  p;
    logic [4:0]  op;

    RSTN = 1'b0;
    ph   = PH0;
    ir   = 16'h0000;
    q    = 16'h0000;
    model_reset();
    @(posedge CLK);
    #2;
    chk_en = 1'b1;

    // 1: reset held with random inputs
    for (int n = 0; n < 6; n++) begin
      drive(4'($urandom), 16'($urandom), 16'($urandom));
    end
    check("rst_pc", alu_if.pc, 16'h0000);
    RSTN = 1'b1;
    drive(PH0, mk(OP_ADD, 3'd2, 3'd3, 5'd0), 16'h1234);
    check("rst_release_wbv", 16'(wb_valid), 16'h0000);
    check("rst_release_sr1", alu_if.sr1, 16'h0000);

    // 2: LI R1,5 then ADD R1,R1,R1
    instr(mk(OP_LI, 3'd1, 3'd0, 5'd5), 16'h0005);
    check("li_wbv", 16'(wb_valid), 16'h0001);
    check("li_wba", 16'(wb_addr), 16'h0001);
    check("li_sr1", alu_if.sr1, 16'h0005);
    check("li_model", m_regs[1], 16'h0005);
    add_i = mk(OP_ADD, 3'd1, 3'd1, 5'd0);
    qv    = exp_rd(3'd1) + exp_rd(3'd1);
    drive(PH0, add_i, qv);
    drive(PH1, add_i, qv);
    check("add_sr1_ph2", alu_if.sr1, 16'h0005);
    check("add_sr2_ph2", alu_if.sr2, 16'h0005);
    drive(PH2, add_i, qv);
    drive(PH3, add_i, qv);
    check("add_sr1", alu_if.sr1, 16'h000A);
    check("add_wbv", 16'(wb_valid), 16'h0001);
    drive(PH0, add_i, 16'h0000);
    check("wbv_one_cycle", 16'(wb_valid), 16'h0000);

    // 3: pc wrap and branch
    instr(mk(OP_B, 3'd0, 3'd0, 5'd0), 16'hFFFF);
    check("b_ffff", alu_if.pc, 16'hFFFF);
    drive(PH0, mk(OP_B, 3'd0, 3'd0, 5'd0), 16'h0040);
    drive(PH1, mk(OP_B, 3'd0, 3'd0, 5'd0), 16'h0040);
    check("pc_wrap", alu_if.pc, 16'h0000);
    drive(PH2, mk(OP_B, 3'd0, 3'd0, 5'd0), 16'h0040);
    drive(PH3, mk(OP_B, 3'd0, 3'd0, 5'd0), 16'h0040);
    check("b_0040", alu_if.pc, 16'h0040);
    check("b_no_wb", 16'(wb_valid), 16'h0000);

    // 4: BNZ not taken, q equals the incremented pc
    instr(mk(OP_BNZ, 3'd1, 3'd0, 5'd0), 16'h0041);
    check("bnz_pc", alu_if.pc, 16'h0041);
    check("bnz_wbv", 16'(wb_valid), 16'h0000);
    check("bnz_r1", alu_if.sr1, 16'h000A);

    // 5: async reset in the middle of an ADD's PH3
    add_i = mk(OP_ADD, 3'd1, 3'd1, 5'd0);
    drive(PH0, add_i, 16'h0014);
    drive(PH1, add_i, 16'h0014);
    drive(PH2, add_i, 16'h0014);
    ph = PH3;
    #1;
    RSTN = 1'b0;
    model_reset();
    @(posedge CLK);
    model_edge();
    #2;
    check("mid_rst_pc", alu_if.pc, 16'h0000);
    check("mid_rst_r1", alu_if.sr1, 16'h0000);
    check("mid_rst_wbv", 16'(wb_valid), 16'h0000);
    RSTN = 1'b1;
    drive(PH0, add_i, 16'h0000);

    // 6: write to R0
    instr(mk(OP_LI, 3'd0, 3'd0, 5'd0), 16'h007F);
    check("r0_sr1", alu_if.sr1, R0Z ? 16'h0000 : 16'h007F);
    check("r0_wbv", 16'(wb_valid), 16'h0001);
    check("r0_wba", 16'(wb_addr), 16'h0000);

    // Randomized traffic: mostly valid phases, some illegal phase codes
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) p = 4'($urandom);
      else                           p = 4'(1 << $urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: op = OP_ADD;
        1: op = OP_LI;
        2: op = OP_B;
        3: op = OP_BNZ;
        4: op = OP_LI;
        default: op = 5'($urandom);
      endcase
      drive(p, {op, 11'($urandom)}, 16'($urandom));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
